// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// default timing and the all-anodes-off pattern.
package ssd_pkg;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } ssd_state_t;

    localparam int DEFAULT_CLK_DIV    = 50000;
    localparam int DEFAULT_GAP_CYCLES = 16;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot counter for the scan controller: times the ON slot (CLK_DIV clocks)
// and the dark gap (GAP_CYCLES clocks), flagging the last clock of each.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic slot_on,
    output logic slot_end,
    output logic gap_end
);

    localparam int CNT_W = $clog2(max_int(CLK_DIV, GAP_CYCLES));

    logic [CNT_W-1:0] cnt;

    assign slot_end = slot_on && (cnt == CNT_W'(CLK_DIV - 1));
    assign gap_end  = !slot_on && (cnt == CNT_W'(GAP_CYCLES - 1));

    // The counter restarts on the clock that ends a phase, so the next phase
    // begins at zero and each phase lasts exactly its programmed length.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (slot_end || gap_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with shadow/active
// register sets committed at frame boundaries. Optional SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_mask,
    output logic [3:0] anode,
    output logic       I3,
    output logic       I2,
    output logic       I1,
    output logic       I0,
    output logic       dp,
    output logic       pending,
    output logic       frame_done,
    output logic       dbg_state
);

    ssd_state_t       state;
    logic [1:0]       idx;
    logic [3:0][3:0]  act_val;
    logic [3:0][3:0]  shd_val;
    logic [3:0]       act_dp;
    logic [3:0]       act_mask;
    logic [3:0]       shd_dp;
    logic [3:0]       shd_mask;
    logic [3:0]       blank;
    logic             slot_end;
    logic             gap_end;
    logic             commit;

    ssd_slot_timer #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .slot_on  (state == ST_ON),
        .slot_end (slot_end),
        .gap_end  (gap_end)
    );

    assign dbg_state = (state == ST_ON);
    assign commit    = (state == ST_GAP) && gap_end && (idx == 2'd3);

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    assign lz[3] = (act_val[3] == 4'd0);
    assign lz[2] = lz[3] && (act_val[2] == 4'd0);
    assign lz[1] = lz[2] && (act_val[1] == 4'd0);
    assign lz[0] = 1'b0;
    assign blank = act_mask | lz;
`else
    assign blank = act_mask;
`endif

    // load is a single-cycle strobe with no backpressure: every strobe seen
    // outside reset is accepted; a later strobe overwrites an uncommitted one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_GAP;
            idx        <= 2'd3;
            act_val    <= '0;
            shd_val    <= '0;
            act_dp     <= '0;
            act_mask   <= '0;
            shd_dp     <= '0;
            shd_mask   <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            anode      <= ANODE_OFF;
            {I3, I2, I1, I0} <= 4'd0;
            dp         <= 1'b1;
        end else begin
            frame_done <= 1'b0;

            case (state)
                ST_ON: begin
                    if (slot_end) state <= ST_GAP;
                end
                default: begin
                    if (gap_end) begin
                        state <= ST_ON;
                        idx   <= idx + 2'd1;
                    end
                end
            endcase

            if (load) begin
                shd_val  <= {digit3, digit2, digit1, digit0};
                shd_dp   <= dp_in;
                shd_mask <= blank_mask;
            end

            // A strobe landing on the boundary bypasses the shadow set.
            if (commit) begin
                if (load) begin
                    act_val    <= {digit3, digit2, digit1, digit0};
                    act_dp     <= dp_in;
                    act_mask   <= blank_mask;
                    frame_done <= 1'b1;
                end else if (pending) begin
                    act_val    <= shd_val;
                    act_dp     <= shd_dp;
                    act_mask   <= shd_mask;
                    frame_done <= 1'b1;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (state == ST_ON) begin
                {I3, I2, I1, I0} <= act_val[idx];
                if (blank[idx]) begin
                    anode <= ANODE_OFF;
                    dp    <= 1'b1;
                end else begin
                    anode <= ~(4'b0001 << idx);
                    dp    <= ~act_dp[idx];
                end
            end else begin
                anode <= ANODE_OFF;
                dp    <= 1'b1;
            end
        end
    end

endmodule
